sprite_fetch_arbiter: RTL and testbench
=======================================

Name: sprite_fetch_arbiter

Overview:
Shares the single address/data port of the sprite register file between the CPU and a per-frame sprite fetch engine. On every vsync it walks the position/rotation registers of PacMan and the four ghosts, then clears the frame lock register, so the CPU can tell a new frame has started. Fetched values go to a staging bank and are then copied atomically to a shadow bank read by the sprite renderers, which prevents tearing. The block sits between the CPU bus, the register file and the renderer.

Parameters:
NSPR, 5, number of sprites fetched (PacMan + 4 ghosts)
LOCK_ADDR, 32, register address of the frame lock register
CPU_MAX_WAIT, 3, maximum number of cycles a pending CPU request may be denied

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
vsync  in  1  single-cycle start-of-frame pulse
cpu_req  in  1  CPU access request; held until cpu_ack
cpu_we  in  1  CPU write (1) or read (0)
cpu_addr  in  6  CPU register address
cpu_wdata  in  16  CPU write data
cpu_ack  out  1  single-cycle grant/completion
cpu_rdata  out  16  read data, valid while cpu_ack is high
reg_addr  out  6  register file address
reg_in  out  16  register file write data
reg_we  out  1  register file write enable
reg_out  in  16  register file combinational read data
spr_x  out  8*NSPR  shadow X positions; sprite i at [8i+7:8i]
spr_y  out  8*NSPR  shadow Y positions
spr_rot  out  8*NSPR  shadow rotations
shadow_valid  out  1  high once the first fetch has completed
frame_done  out  1  single-cycle pulse when the shadow bank updates
busy  out  1  fetch in progress

Behaviour:
- Interface: reset is synchronous and active-high; clock is clk.
- Reset values:
  - All outputs 0, including shadow and staging banks.
  - FSM in IDLE; pending flag, wait counter and grant pointer cleared.
  - Reset mid-fetch aborts the fetch; the shadow bank is not updated.
- Sprite base addresses: 0, 8, 14, 20, 26. Field offsets: x=+0, y=+1, rot=+2. Sequence order is sprite-major: x, y, rot per sprite.
- FSM states:
  - IDLE: on vsync go to FETCH next cycle; idx=0.
  - FETCH: one read per granted cycle; reg_out is captured into staging at idx; idx increments. After 3*NSPR reads go to UNLOCK.
  - UNLOCK: one write of 0 to LOCK_ADDR when granted. In the following cycle:
    - copy staging to shadow;
    - pulse frame_done;
    - set shadow_valid;
    - go to IDLE, or straight to FETCH if the pending flag is set.
- busy = (state != IDLE).
- Arbitration, per cycle, on the shared port:
  - If the FSM is in IDLE, the CPU wins whenever cpu_req is high.
  - Otherwise the fetch engine wins, unless cpu_req has been denied for CPU_MAX_WAIT consecutive cycles; in that case the CPU is granted and the counter clears.
  - A fetch step that is not granted is retried on the next cycle; idx does not advance.
- CPU access: when granted, cpu_ack=1 in that same cycle and the port is driven from cpu_* signals.
  - Read: cpu_rdata = reg_out, combinational.
  - Write: takes effect at the clock edge.
  - The CPU must drop or change cpu_req after ack; back-to-back requests are allowed.
- Latency with no CPU traffic:
  - vsync sampled at edge 0.
  - Reads in cycles 1..3*NSPR.
  - Unlock write in cycle 3*NSPR+1.
  - frame_done in cycle 3*NSPR+2 (17 for NSPR=5).
- vsync while busy: sets the pending flag. Only one pending fetch is held; further vsyncs are dropped.
- vsync in the same cycle as frame_done: counts as pending and restarts the fetch.
- A CPU write to a register that has already been fetched in the current pass is not seen until the next frame.

Optional Feature:
SPRITE_FETCH_TIMER_EN
- Defined:
  - Adds field offset +3 (animation timer), giving 4 reads per sprite in the order x, y, rot, timer.
  - Adds output port spr_timer (8*NSPR bits), with the same staging/shadow behaviour as the other fields.
  - frame_done moves to cycle 4*NSPR+2 (22).
- Undefined: 3 reads per sprite; spr_timer does not exist.

Decomposition:
- Shared package sprite_pkg:
  - Register address constants: sprite bases, field offsets, LOCK_ADDR, SCORE and SCORE_DISP.
  - FSM state enum {IDLE, FETCH, UNLOCK}.
  - Fields-per-sprite constant, depending on SPRITE_FETCH_TIMER_EN.
- Natural sub-module: sprite_port_mux, the combinational grant logic plus the starvation wait counter. The FSM and the staging/shadow banks stay in the top module.

Test Plan:
- Reset, then preload regs 0/1/2 = 0x10/0x20/0x01 and 8/9/10 = 0x30/0x40/0x02; pulse vsync -> frame_done at cycle 17, spr_x[7:0]=0x10, spr_x[15:8]=0x30, spr_rot[15:8]=0x02, reg 32 reads 0, shadow_valid=1.
- CPU holds a read request throughout a fetch -> cpu_ack every 4th cycle (after 3 denials); frame_done delayed by exactly the number of CPU grants.
- CPU write to reg 0 = 0x55 at cycle 5 of a fetch -> current shadow keeps the old x; the next frame shows 0x55.
- vsync twice during a fetch -> exactly one extra pass: FETCH begins the cycle after frame_done, and only two frame_done pulses in total.
- Assert reset at cycle 8 of a fetch -> all outputs 0; a new vsync then completes normally at cycle 17.
- CPU write 0x1234 to SCORE while IDLE -> cpu_ack in the same cycle; a read back returns 0x1234.

Source files
------------

// File: rtl/sprite_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | sprite_pkg                                                                |
// | Register map, field layout and fetch FSM states for sprite_fetch_arbiter. |
// | Build option: SPRITE_FETCH_TIMER_EN adds the animation-timer field.       |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package sprite_pkg;

  localparam logic [5:0] REG_SPR_BASE_0 = 6'd0;
  localparam logic [5:0] REG_SPR_BASE_1 = 6'd8;
  localparam logic [5:0] REG_SPR_BASE_2 = 6'd14;
  localparam logic [5:0] REG_SPR_BASE_3 = 6'd20;
  localparam logic [5:0] REG_SPR_BASE_4 = 6'd26;

  localparam logic [1:0] OFF_X     = 2'd0;
  localparam logic [1:0] OFF_Y     = 2'd1;
  localparam logic [1:0] OFF_ROT   = 2'd2;
  localparam logic [1:0] OFF_TIMER = 2'd3;

  localparam logic [5:0] REG_LOCK_ADDR  = 6'd32;
  localparam logic [5:0] REG_SCORE      = 6'd33;
  localparam logic [5:0] REG_SCORE_DISP = 6'd34;

`ifdef SPRITE_FETCH_TIMER_EN
  localparam int FIELDS = 4;
`else
  localparam int FIELDS = 3;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    UNLOCK = 2'd2
  } fetch_state_t;

  function automatic logic [5:0] spr_base(input logic [2:0] idx);
    case (idx)
      3'd0:    spr_base = REG_SPR_BASE_0;
      3'd1:    spr_base = REG_SPR_BASE_1;
      3'd2:    spr_base = REG_SPR_BASE_2;
      3'd3:    spr_base = REG_SPR_BASE_3;
      3'd4:    spr_base = REG_SPR_BASE_4;
      default: spr_base = REG_SPR_BASE_0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_port_mux.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | sprite_port_mux                                                           |
// | Grants the shared register-file port to the CPU or the fetch engine,      |
// | with a starvation counter that bounds how long the CPU can be denied.     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module sprite_port_mux #(
  parameter int CPU_MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [5:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  input  logic        fetch_req,
  input  logic        fetch_we,
  input  logic [5:0]  fetch_addr,
  output logic        fetch_grant,
  output logic [5:0]  reg_addr,
  output logic [15:0] reg_in,
  output logic        reg_we,
  input  logic [15:0] reg_out
);

  localparam int WW = $clog2(CPU_MAX_WAIT + 1);

  logic [WW-1:0] wait_cnt;
  logic          starve;
  logic          cpu_grant;

  // The engine owns the port only while it has something to do there.
  assign starve      = (wait_cnt >= WW'(CPU_MAX_WAIT));
  assign cpu_grant   = cpu_req && (!fetch_req || starve);
  assign fetch_grant = fetch_req && !cpu_grant;
  assign cpu_ack     = cpu_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (cpu_req && !cpu_grant) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_comb begin
    reg_addr = 6'd0;
    reg_in   = 16'd0;
    reg_we   = 1'b0;
    if (cpu_grant) begin
      reg_addr = cpu_addr;
      reg_in   = cpu_wdata;
      reg_we   = cpu_we;
    end else if (fetch_grant) begin
      reg_addr = fetch_addr;
      reg_we   = fetch_we;
    end
  end

  assign cpu_rdata = (cpu_grant && !cpu_we) ? reg_out : 16'd0;

endmodule
`default_nettype wire

// File: rtl/sprite_fetch_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | sprite_fetch_arbiter                                                      |
// | Per-vsync sprite register fetch into a staging bank, lock clear, then an  |
// | atomic copy to the shadow bank; shares the register port with the CPU.    |
// | Build option: SPRITE_FETCH_TIMER_EN (adds spr_timer, 4 fields/sprite).    |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module sprite_fetch_arbiter
  import sprite_pkg::*;
#(
  parameter int NSPR         = 5,
  parameter int LOCK_ADDR    = 32,
  parameter int CPU_MAX_WAIT = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vsync,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [5:0]          cpu_addr,
  input  logic [15:0]         cpu_wdata,
  output logic                cpu_ack,
  output logic [15:0]         cpu_rdata,
  output logic [5:0]          reg_addr,
  output logic [15:0]         reg_in,
  output logic                reg_we,
  input  logic [15:0]         reg_out,
  output logic [8*NSPR-1:0]   spr_x,
  output logic [8*NSPR-1:0]   spr_y,
  output logic [8*NSPR-1:0]   spr_rot,
`ifdef SPRITE_FETCH_TIMER_EN
  output logic [8*NSPR-1:0]   spr_timer,
`endif
  output logic                shadow_valid,
  output logic                frame_done,
  output logic                busy
);

  fetch_state_t state, state_nx;
  logic [2:0]   spr_idx, spr_nx;
  logic [1:0]   fld_idx, fld_nx;
  logic         lock_written, lock_written_nx;
  logic         pending, pending_nx;
  logic         capture;
  logic         last_read;

  logic         fetch_req;
  logic         fetch_we;
  logic [5:0]   fetch_addr;
  logic         fetch_grant;

  logic [8*NSPR-1:0] stg_x;
  logic [8*NSPR-1:0] stg_y;
  logic [8*NSPR-1:0] stg_rot;
`ifdef SPRITE_FETCH_TIMER_EN
  logic [8*NSPR-1:0] stg_timer;
`endif

  // UNLOCK has two phases: the lock write, then the publish cycle.
  assign fetch_req  = (state == FETCH) || ((state == UNLOCK) && !lock_written);
  assign fetch_we   = (state == UNLOCK);
  assign fetch_addr = (state == UNLOCK) ? 6'(LOCK_ADDR)
                                        : spr_base(spr_idx) + {4'd0, fld_idx};
  assign last_read  = (spr_idx == 3'(NSPR - 1)) && (fld_idx == 2'(FIELDS - 1));
  assign busy       = (state != IDLE);

  sprite_port_mux #(
    .CPU_MAX_WAIT (CPU_MAX_WAIT)
  ) u_port_mux (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .fetch_req   (fetch_req),
    .fetch_we    (fetch_we),
    .fetch_addr  (fetch_addr),
    .fetch_grant (fetch_grant),
    .reg_addr    (reg_addr),
    .reg_in      (reg_in),
    .reg_we      (reg_we),
    .reg_out     (reg_out)
  );

  always_comb begin
    state_nx        = state;
    spr_nx          = spr_idx;
    fld_nx          = fld_idx;
    lock_written_nx = lock_written;
    pending_nx      = pending;
    capture         = 1'b0;
    frame_done      = 1'b0;
    case (state)
      IDLE: begin
        if (vsync) begin
          state_nx = FETCH;
          spr_nx   = 3'd0;
          fld_nx   = 2'd0;
        end
      end
      FETCH: begin
        if (vsync) pending_nx = 1'b1;
        if (fetch_grant) begin
          capture = 1'b1;
          if (last_read) begin
            state_nx        = UNLOCK;
            lock_written_nx = 1'b0;
          end else if (fld_idx == 2'(FIELDS - 1)) begin
            fld_nx = 2'd0;
            spr_nx = spr_idx + 3'd1;
          end else begin
            fld_nx = fld_idx + 2'd1;
          end
        end
      end
      UNLOCK: begin
        if (!lock_written) begin
          if (vsync) pending_nx = 1'b1;
          if (fetch_grant) lock_written_nx = 1'b1;
        end else begin
          frame_done      = 1'b1;
          lock_written_nx = 1'b0;
          spr_nx          = 3'd0;
          fld_nx          = 2'd0;
          // A vsync landing on the publish cycle restarts just like a pending one.
          if (pending || vsync) begin
            state_nx   = FETCH;
            pending_nx = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      spr_idx      <= 3'd0;
      fld_idx      <= 2'd0;
      lock_written <= 1'b0;
      pending      <= 1'b0;
      stg_x        <= '0;
      stg_y        <= '0;
      stg_rot      <= '0;
      spr_x        <= '0;
      spr_y        <= '0;
      spr_rot      <= '0;
`ifdef SPRITE_FETCH_TIMER_EN
      stg_timer    <= '0;
      spr_timer    <= '0;
`endif
      shadow_valid <= 1'b0;
    end else begin
      state        <= state_nx;
      spr_idx      <= spr_nx;
      fld_idx      <= fld_nx;
      lock_written <= lock_written_nx;
      pending      <= pending_nx;
      if (capture) begin
        case (fld_idx)
          OFF_X:     stg_x[{spr_idx, 3'b000} +: 8]     <= reg_out[7:0];
          OFF_Y:     stg_y[{spr_idx, 3'b000} +: 8]     <= reg_out[7:0];
          OFF_ROT:   stg_rot[{spr_idx, 3'b000} +: 8]   <= reg_out[7:0];
`ifdef SPRITE_FETCH_TIMER_EN
          OFF_TIMER: stg_timer[{spr_idx, 3'b000} +: 8] <= reg_out[7:0];
`endif
          default: ;
        endcase
      end
      if (frame_done) begin
        spr_x        <= stg_x;
        spr_y        <= stg_y;
        spr_rot      <= stg_rot;
`ifdef SPRITE_FETCH_TIMER_EN
        spr_timer    <= stg_timer;
`endif
        shadow_valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_fetch_arbiter.sv
`default_nettype none
// tb_sprite_fetch_arbiter: table vectors, hand-written frame sequences and
// randomized frames checked against a register-map reference model.
module tb_sprite_fetch_arbiter;

  localparam int NSPR  = 5;
  localparam int LOCK  = 32;
  localparam int SCORE = 33;
`ifdef SPRITE_FETCH_TIMER_EN
  localparam int NF = 4;
`else
  localparam int NF = 3;
`endif
  localparam int FD = NF * NSPR + 2;

  int base_tbl [NSPR] = '{0, 8, 14, 20, 26};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vsync = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [5:0]  cpu_addr = 6'd0;
  logic [15:0] cpu_wdata = 16'd0;
  logic        mem_clr = 1'b1;
  wire         cpu_ack;
  wire  [15:0] cpu_rdata;
  wire  [5:0]  reg_addr;
  wire  [15:0] reg_in;
  wire         reg_we;
  wire  [15:0] reg_out;
  wire  [8*NSPR-1:0] spr_x, spr_y, spr_rot;
`ifdef SPRITE_FETCH_TIMER_EN
  wire  [8*NSPR-1:0] spr_timer;
`endif
  wire         shadow_valid, frame_done, busy;

  sprite_fetch_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .vsync        (vsync),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ack      (cpu_ack),
    .cpu_rdata    (cpu_rdata),
    .reg_addr     (reg_addr),
    .reg_in       (reg_in),
    .reg_we       (reg_we),
    .reg_out      (reg_out),
    .spr_x        (spr_x),
    .spr_y        (spr_y),
    .spr_rot      (spr_rot),
`ifdef SPRITE_FETCH_TIMER_EN
    .spr_timer    (spr_timer),
`endif
    .shadow_valid (shadow_valid),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Register file the DUT talks to: combinational read, write on the edge.
  logic [15:0] mem [64];
  assign reg_out = mem[reg_addr];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int a = 0; a < 64; a++) mem[a] <= 16'h0;
    end else if (reg_we) begin
      mem[reg_addr] <= reg_in;
    end
  end

  logic [15:0] ref_mem [64];
  logic [15:0] snap [64];
  int          fd_q [$];
  int          ack_q [$];
  logic        busy_log [256];
  int          cyc;
  int          ncmp = 0;
  int          nerr = 0;

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_spr_x"}, 64'(spr_x), 64'h0);
    check({tag, "_spr_y"}, 64'(spr_y), 64'h0);
    check({tag, "_spr_rot"}, 64'(spr_rot), 64'h0);
`ifdef SPRITE_FETCH_TIMER_EN
    check({tag, "_spr_timer"}, 64'(spr_timer), 64'h0);
`endif
    check({tag, "_ctrl"}, {shadow_valid, frame_done, busy, cpu_ack, reg_we}, 64'h0);
    check({tag, "_port"}, {reg_addr, reg_in, cpu_rdata}, 64'h0);
  endtask

  task automatic check_shadow(input string tag);
    for (int i = 0; i < NSPR; i++) begin
      check({tag, "_x"}, 64'(spr_x[8*i +: 8]), 64'(snap[base_tbl[i] + 0][7:0]));
      check({tag, "_y"}, 64'(spr_y[8*i +: 8]), 64'(snap[base_tbl[i] + 1][7:0]));
      check({tag, "_rot"}, 64'(spr_rot[8*i +: 8]), 64'(snap[base_tbl[i] + 2][7:0]));
`ifdef SPRITE_FETCH_TIMER_EN
      check({tag, "_timer"}, 64'(spr_timer[8*i +: 8]), 64'(snap[base_tbl[i] + 3][7:0]));
`endif
    end
  endtask

  task automatic check_fd(input string tag, input int n, input int first);
    check({tag, "_fd_count"}, 64'(fd_q.size()), 64'(n));
    check({tag, "_fd_cycle"}, 64'((fd_q.size() > 0) ? fd_q[0] : -1), 64'(first));
  endtask

  // Called at mid-cycle: logs events and keeps the register model current.
  task automatic observe();
    if (frame_done) begin
      fd_q.push_back(cyc);
      ref_mem[LOCK] = 16'h0;
    end
    if (cpu_ack) begin
      ack_q.push_back(cyc);
      if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      else check("cpu_rdata", 64'(cpu_rdata), 64'(ref_mem[cpu_addr]));
    end
  endtask

  task automatic cpu_access(input logic we, input logic [5:0] addr, input logic [15:0] wd,
                            output logic [15:0] rd);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    @(negedge clk);
    check("ack_same_cycle", 64'(cpu_ack), 64'h1);
    rd = cpu_rdata;
    observe();
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  // Cycle 0 is the vsync cycle; bit c of vs_mask drives vsync in cycle c.
  task automatic run_seq(input logic [63:0] vs_mask, input int rst_at, input int cpu_at,
                         input bit hold, input logic we, input logic [5:0] addr,
                         input logic [15:0] wd, input int ncyc);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    for (int a = 0; a < 64; a++) snap[a] = ref_mem[a];
    fd_q.delete();
    ack_q.delete();
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    for (cyc = 0; cyc <= ncyc; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
      end
      vsync = (cyc < 64) ? vs_mask[cyc] : 1'b0;
      reset = (cyc == rst_at);
      if (hold) cpu_req = 1'b1;
      else begin
        if (got) cpu_req = 1'b0;
        if (cyc == cpu_at) cpu_req = 1'b1;
      end
      @(negedge clk);
      got = cpu_ack;
      busy_log[cyc] = busy;
      observe();
      if (cyc == 1) check("busy_c1", 64'(busy), 64'h1);
      if (rst_at >= 0 && cyc == rst_at + 1) check_zero("rst_mid");
    end
    vsync = 1'b0;
    cpu_req = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    int t, e, g, nbad, nack;

    for (int a = 0; a < 64; a++) ref_mem[a] = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mem_clr = 1'b0;
    @(negedge clk);
    check_zero("rst");

    // Directed frame with known sprite registers.
    cpu_access(1'b1, 6'd0, 16'h0010, rd);
    cpu_access(1'b1, 6'd1, 16'h0020, rd);
    cpu_access(1'b1, 6'd2, 16'h0001, rd);
    cpu_access(1'b1, 6'd8, 16'h0030, rd);
    cpu_access(1'b1, 6'd9, 16'h0040, rd);
    cpu_access(1'b1, 6'd10, 16'h0002, rd);
    cpu_access(1'b1, 6'(LOCK), 16'hFFFF, rd);
    run_seq(64'h1, -1, -1, 1'b0, 1'b0, 6'd0, 16'h0, 25);
    check_fd("basic", 1, FD);
    check("basic_x0", 64'(spr_x[7:0]), 64'h10);
    check("basic_x1", 64'(spr_x[15:8]), 64'h30);
    check("basic_rot1", 64'(spr_rot[15:8]), 64'h02);
    check("basic_valid", 64'(shadow_valid), 64'h1);
    check("basic_idle_after", 64'(busy_log[FD + 1]), 64'h0);
    check_shadow("basic");
    cpu_access(1'b0, 6'(LOCK), 16'h0, rd);
    check("lock_cleared", 64'(rd), 64'h0);

    // IDLE CPU accesses from a table.
    tbl[0] = '{1'b1, 6'(SCORE), 16'h1234, 16'h0};
    tbl[1] = '{1'b0, 6'(SCORE), 16'h0, 16'h1234};
    tbl[2] = '{1'b1, 6'd34, 16'hBEEF, 16'h0};
    tbl[3] = '{1'b0, 6'd34, 16'h0, 16'hBEEF};
    tbl[4] = '{1'b0, 6'(SCORE), 16'h0, 16'h1234};
    tbl[5] = '{1'b1, 6'd40, 16'h0F0F, 16'h0};
    tbl[6] = '{1'b0, 6'd40, 16'h0, 16'h0F0F};
    tbl[7] = '{1'b0, 6'd8, 16'h0, 16'h0030};
    for (int i = 0; i < 8; i++) begin
      cpu_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd);
      if (!tbl[i].we) check("tbl_rdata", 64'(rd), 64'(tbl[i].exp));
    end

    // CPU holding a read across a whole fetch.
    e = 0; g = 0; t = 0;
    while (e < NF * NSPR + 1) begin
      t++;
      if (t % 4 == 0) g++;
      else e++;
    end
    run_seq(64'h1, -1, -1, 1'b1, 1'b0, 6'(SCORE), 16'h0, t + 6);
    check_fd("hold", 1, t + 1);
    nbad = 0; nack = 0;
    foreach (ack_q[k]) begin
      if (ack_q[k] >= 1 && ack_q[k] <= t) begin
        nack++;
        if (ack_q[k] % 4 != 0) nbad++;
      end
    end
    check("hold_grants", 64'(nack), 64'(g));
    check("hold_grant_spacing", 64'(nbad), 64'h0);

    // CPU write to an already-fetched register mid-frame.
    run_seq(64'h1, -1, 5, 1'b0, 1'b1, 6'd0, 16'h0055, 30);
    check_fd("late_wr", 1, FD + 1);
    check("late_wr_ack_cycle", 64'((ack_q.size() > 0) ? ack_q[0] : -1), 64'd8);
    check("late_wr_old_x0", 64'(spr_x[7:0]), 64'(snap[0][7:0]));
    run_seq(64'h1, -1, -1, 1'b0, 1'b0, 6'd0, 16'h0, 25);
    check_fd("next_frame", 1, FD);
    check("next_frame_x0", 64'(spr_x[7:0]), 64'h55);

    // Extra vsyncs during a fetch produce exactly one more pass.
    run_seq(64'h49, -1, -1, 1'b0, 1'b0, 6'd0, 16'h0, 3 * FD);
    check("dbl_fd_count", 64'(fd_q.size()), 64'd2);
    check("dbl_fd_second", 64'((fd_q.size() > 1) ? fd_q[1] : -1), 64'(2 * FD));
    check("dbl_restart_busy", 64'(busy_log[FD + 1]), 64'h1);

    // vsync coinciding with frame_done restarts the fetch.
    run_seq(64'h1 | (64'h1 << FD), -1, -1, 1'b0, 1'b0, 6'd0, 16'h0, 2 * FD + 4);
    check("coinc_fd_count", 64'(fd_q.size()), 64'd2);
    check("coinc_fd_second", 64'((fd_q.size() > 1) ? fd_q[1] : -1), 64'(2 * FD));

    // Reset in the middle of a fetch, then a clean frame.
    run_seq(64'h1, 8, -1, 1'b0, 1'b0, 6'd0, 16'h0, 25);
    check("rst_mid_no_fd", 64'(fd_q.size()), 64'h0);
    run_seq(64'h1, -1, -1, 1'b0, 1'b0, 6'd0, 16'h0, 25);
    check_fd("after_rst", 1, FD);
    check("after_rst_valid", 64'(shadow_valid), 64'h1);
    check_shadow("after_rst");

    // Randomized register contents and IDLE traffic.
    for (int it = 0; it < 6; it++) begin
      for (int s = 0; s < NSPR; s++)
        for (int f = 0; f < NF; f++)
          cpu_access(1'b1, 6'(base_tbl[s] + f), 16'($urandom), rd);
      for (int k = 0; k < 3; k++)
        cpu_access(1'($urandom_range(0, 1)), 6'($urandom_range(33, 63)), 16'($urandom), rd);
      run_seq(64'h1, -1, -1, 1'b0, 1'b0, 6'd0, 16'h0, FD + 3);
      check_fd("rand", 1, FD);
      check_shadow("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
`default_nettype wire
